// File: rtl/load_store_sequencer_if.sv
// Bundle between the execute stage, the load/store sequencer and a word-addressed RAM port.
// slave = the sequencer; master = execute stage plus RAM (the environment around it).
interface load_store_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [31:0]           req_store_value;

  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_efault;
  logic [31:0]           resp_load_value;

  logic                  ram_req_valid;
  logic                  ram_req_ready;
  logic                  ram_req_write;
  logic [ADDR_WIDTH-3:0] ram_req_address;
  logic [31:0]           ram_req_data;
  logic                  ram_resp_valid;
  logic [31:0]           ram_resp_data;

  modport slave (
    input  req_valid, req_store, req_funct3, req_address, req_store_value,
    input  resp_ready, ram_req_ready, ram_resp_valid, ram_resp_data,
    output req_ready, resp_valid, resp_efault, resp_load_value,
    output ram_req_valid, ram_req_write, ram_req_address, ram_req_data
  );

  modport master (
    output req_valid, req_store, req_funct3, req_address, req_store_value,
    output resp_ready, ram_req_ready, ram_resp_valid, ram_resp_data,
    input  req_ready, resp_valid, resp_efault, resp_load_value,
    input  ram_req_valid, ram_req_write, ram_req_address, ram_req_data
  );
endinterface

// File: rtl/load_store_sequencer.sv
// One-at-a-time RISC-V load/store sequencer over a 32-bit word RAM port, with the
// byte-lane helper (alignment, extension, fault detection, store merge) alongside it.
module load_store (
  input  logic [2:0]  funct3,
  input  logic [1:0]  address,
  input  logic [31:0] store_value,
  input  logic [31:0] ram_load_value,
  output logic        efault,
  output logic [31:0] load_value,
  output logic [31:0] ram_store_value
);
  logic [4:0]  shamt;
  logic [31:0] lane;

  assign shamt = {address, 3'b000};
  assign lane  = ram_load_value >> shamt;

  // Unused or faulting paths yield 0 rather than x so nothing undefined reaches ports.
  always_comb begin
    efault          = 1'b0;
    load_value      = '0;
    ram_store_value = '0;
    case (funct3[1:0])
      2'b00: begin
        load_value      = funct3[2] ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        ram_store_value = (ram_load_value & ~(32'h0000_00ff << shamt))
                        | ({24'h0, store_value[7:0]} << shamt);
      end
      2'b01: begin
        efault          = address[0];
        load_value      = funct3[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
        ram_store_value = (ram_load_value & ~(32'h0000_ffff << shamt))
                        | ({16'h0, store_value[15:0]} << shamt);
      end
      2'b10: begin
        efault          = |address;
        load_value      = ram_load_value;
        ram_store_value = store_value;
      end
      default: efault = 1'b1;
    endcase
  end
endmodule

module load_store_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  load_store_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DECIDE, READ, READ_WAIT, WRITE, RESP} state_t;

  state_t                state;
  state_t                state_next;
  logic                  st_store;
  logic [2:0]            st_funct3;
  logic [ADDR_WIDTH-1:0] st_address;
  logic [31:0]           st_store_value;
  logic [31:0]           ram_data;
  logic [31:0]           load_result;
  logic                  efault_result;
  logic                  ls_efault;
  logic [31:0]           ls_load_value;
  logic [31:0]           ls_ram_store_value;
  logic                  fault;

  load_store u_load_store (
    .funct3          (st_funct3),
    .address         (st_address[1:0]),
    .store_value     (st_store_value),
    .ram_load_value  (bus.ram_resp_data),
    .efault          (ls_efault),
    .load_value      (ls_load_value),
    .ram_store_value (ls_ram_store_value)
  );

  // Stores have no unsigned forms, so funct3[2] on a store is illegal.
  assign fault = ls_efault || (st_store && st_funct3[2]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next        = state;
    bus.req_ready     = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.ram_req_valid = 1'b0;
    bus.ram_req_write = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_next = DECIDE;
      end
      DECIDE: begin
        if (fault)                                  state_next = RESP;
        else if (st_store && st_funct3 == 3'b010)   state_next = WRITE;
        else                                        state_next = READ;
      end
      READ: begin
        bus.ram_req_valid = 1'b1;
        if (bus.ram_req_ready) state_next = READ_WAIT;
      end
      READ_WAIT: begin
        if (bus.ram_resp_valid) state_next = st_store ? WRITE : RESP;
      end
      WRITE: begin
        bus.ram_req_valid = 1'b1;
        bus.ram_req_write = 1'b1;
        if (bus.ram_req_ready) state_next = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_store       <= 1'b0;
      st_funct3      <= '0;
      st_address     <= '0;
      st_store_value <= '0;
      ram_data       <= '0;
      load_result    <= '0;
      efault_result  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            st_store       <= bus.req_store;
            st_funct3      <= bus.req_funct3;
            st_address     <= bus.req_address;
            st_store_value <= bus.req_store_value;
            load_result    <= '0;
            efault_result  <= 1'b0;
          end
        end
        DECIDE: begin
          if (fault)                                efault_result <= 1'b1;
          else if (st_store && st_funct3 == 3'b010) ram_data      <= st_store_value;
        end
        READ_WAIT: begin
          if (bus.ram_resp_valid) begin
            if (st_store) ram_data    <= ls_ram_store_value;
            else          load_result <= ls_load_value;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_req_address = st_address[ADDR_WIDTH-1:2];
  assign bus.ram_req_data    = ram_data;
  assign bus.resp_efault     = efault_result;
  assign bus.resp_load_value = load_result;
endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer: vector table through a scoreboard, a small RAM model,
// and hand sequences for backpressure and reset during an access.
module tb_load_store_sequencer;
  localparam int AW = 32;

  logic clock;
  logic reset;

  load_store_sequencer_if #(.ADDR_WIDTH(AW)) bus ();
  load_store_sequencer #(.ADDR_WIDTH(AW)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] value;
    logic [31:0] pre_word;
    logic        efault;
    logic [31:0] load;
    int unsigned lat;
    int unsigned reads;
    int unsigned writes;
    logic        chk_word;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    vec_t        v;
    int unsigned accept;
    int unsigned rd_base;
    int unsigned wr_base;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[$];
  logic [31:0] mem [16];
  int unsigned cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, expect_done = 0;
  int unsigned stale_req = 0, stale_done = 0;
  int          errors = 0, checks = 0;
  logic        ram_mute = 1'b0;
  logic [31:0] last_wr_data = '0;
  logic [29:0] last_wr_addr = '0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(logic st, logic [2:0] f3, logic [31:0] addr, logic [31:0] value,
                              logic [31:0] pre, logic ef, logic [31:0] ld, int unsigned lat,
                              int unsigned rd, int unsigned wr, logic cw, logic [31:0] word);
    vec_t v;
    v.store = st; v.funct3 = f3; v.addr = addr; v.value = value; v.pre_word = pre;
    v.efault = ef; v.load = ld; v.lat = lat; v.reads = rd; v.writes = wr;
    v.chk_word = cw; v.word = word;
    return v;
  endfunction

  // RAM model: command handshake seen at negedge, acted on just after the posedge.
  initial begin
    logic        hs, w;
    logic [29:0] a;
    logic [31:0] d;
    bus.ram_resp_valid = 1'b0;
    bus.ram_resp_data  = '0;
    forever begin
      @(negedge clock);
      hs = bus.ram_req_valid && bus.ram_req_ready;
      w  = bus.ram_req_write;
      a  = bus.ram_req_address;
      d  = bus.ram_req_data;
      @(posedge clock);
      #1;
      bus.ram_resp_valid = 1'b0;
      if (stale_req != stale_done) begin
        stale_done++;
        bus.ram_resp_valid = 1'b1;
        bus.ram_resp_data  = 32'hdead_beef;
      end else if (hs && !reset) begin
        if (w) begin
          wr_cnt++;
          last_wr_data = d;
          last_wr_addr = a;
        end else begin
          rd_cnt++;
          if (!ram_mute) begin
            bus.ram_resp_valid = 1'b1;
            bus.ram_resp_data  = mem[a[3:0]];
          end
        end
      end
    end
  end

  // Monitor: stability under backpressure and scoreboard comparison on response handshake.
  initial begin
    logic        ram_stall, resp_stall, h_write, h_ef;
    logic [29:0] h_addr;
    logic [31:0] h_data, h_load;
    exp_t        e;
    ram_stall = 1'b0; resp_stall = 1'b0;
    h_write = 1'b0; h_ef = 1'b0; h_addr = '0; h_data = '0; h_load = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ram_stall  = 1'b0;
        resp_stall = 1'b0;
      end else begin
        if (ram_stall) begin
          check("ram_req_valid held", 32'(bus.ram_req_valid), 32'd1);
          check("ram_req_write held", 32'(bus.ram_req_write), 32'(h_write));
          check("ram_req_address held", 32'(bus.ram_req_address), 32'(h_addr));
          check("ram_req_data held", bus.ram_req_data, h_data);
        end
        if (resp_stall) begin
          check("resp_valid held", 32'(bus.resp_valid), 32'd1);
          check("resp_efault held", 32'(bus.resp_efault), 32'(h_ef));
          check("resp_load_value held", bus.resp_load_value, h_load);
        end
        ram_stall  = bus.ram_req_valid && !bus.ram_req_ready;
        resp_stall = bus.resp_valid && !bus.resp_ready;
        h_write = bus.ram_req_write;
        h_addr  = bus.ram_req_address;
        h_data  = bus.ram_req_data;
        h_ef    = bus.resp_efault;
        h_load  = bus.resp_load_value;
        if (bus.resp_valid && bus.resp_ready) begin
          if (sb_q.size() == 0) begin
            check("response with empty scoreboard", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            check("resp_efault", 32'(bus.resp_efault), 32'(e.v.efault));
            check("resp_load_value", bus.resp_load_value, e.v.load);
            if (e.v.lat != 0) check("latency", 32'(cyc + 1 - e.accept), 32'(e.v.lat));
            check("ram reads", 32'(rd_cnt - e.rd_base), 32'(e.v.reads));
            check("ram writes", 32'(wr_cnt - e.wr_base), 32'(e.v.writes));
            if (e.v.chk_word) begin
              check("ram write data", last_wr_data, e.v.word);
              check("ram write word address", 32'(last_wr_addr), 32'(e.v.addr[31:2]));
            end
            done_cnt++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic submit(input vec_t v);
    exp_t        e;
    int unsigned n;
    mem[v.addr[5:2]] = v.pre_word;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      step();
      n++;
    end
    check("req_ready before request", 32'(bus.req_ready), 32'd1);
    bus.req_valid       = 1'b1;
    bus.req_store       = v.store;
    bus.req_funct3      = v.funct3;
    bus.req_address     = v.addr;
    bus.req_store_value = v.value;
    e.v = v; e.accept = cyc + 1; e.rd_base = rd_cnt; e.wr_base = wr_cnt;
    sb_q.push_back(e);
    step();
    bus.req_valid       = 1'b0;
    bus.req_store       = 1'($urandom);
    bus.req_funct3      = 3'($urandom);
    bus.req_address     = $urandom;
    bus.req_store_value = $urandom;
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (done_cnt < expect_done && n < 100) begin
      step();
      n++;
    end
    check("responses completed", 32'(done_cnt), 32'(expect_done));
    if (done_cnt != expect_done) begin
      sb_q.delete();
      expect_done = done_cnt;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " resp_efault"}, 32'(bus.resp_efault), 32'd0);
    check({tag, " resp_load_value"}, bus.resp_load_value, 32'd0);
    check({tag, " ram_req_valid"}, 32'(bus.ram_req_valid), 32'd0);
    check({tag, " ram_req_write"}, 32'(bus.ram_req_write), 32'd0);
    check({tag, " ram_req_address"}, 32'(bus.ram_req_address), 32'd0);
    check({tag, " ram_req_data"}, bus.ram_req_data, 32'd0);
  endtask

  initial begin
    int unsigned n, wr_base;
    vec_t        bp;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
    bus.req_address = '0; bus.req_store_value = '0;
    bus.resp_ready = 1'b1; bus.ram_req_ready = 1'b1;
    for (int unsigned i = 0; i < 16; i++) mem[i] = '0;

    //            st f3      addr   value         preload       ef ld            lat rd wr cw word
    vecs.push_back(mk(0, 3'b000, 32'd1,  32'h0,        32'h456789ab, 0, 32'hffffff89, 4, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b100, 32'd1,  32'h0,        32'h456789ab, 0, 32'h00000089, 4, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'd3,  32'hffffffff, 32'h456789ab, 0, 32'h0,        5, 1, 1, 1, 32'hff6789ab));
    vecs.push_back(mk(0, 3'b001, 32'd1,  32'h0,        32'h456789ab, 1, 32'h0,        2, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b010, 32'd2,  32'hffffffff, 32'h456789ab, 1, 32'h0,        2, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b010, 32'd0,  32'hffffffff, 32'h456789ab, 0, 32'h0,        3, 0, 1, 1, 32'hffffffff));
    vecs.push_back(mk(0, 3'b001, 32'd4,  32'h0,        32'h8000f00d, 0, 32'hfffff00d, 4, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b001, 32'd6,  32'h0,        32'h8000f00d, 0, 32'hffff8000, 4, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b101, 32'd6,  32'h0,        32'h8000f00d, 0, 32'h00008000, 4, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b010, 32'd4,  32'h0,        32'h8000f00d, 0, 32'h8000f00d, 4, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b001, 32'd6,  32'h1234abcd, 32'h8000f00d, 0, 32'h0,        5, 1, 1, 1, 32'habcdf00d));
    vecs.push_back(mk(1, 3'b100, 32'd0,  32'h000000ff, 32'h456789ab, 1, 32'h0,        2, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b011, 32'd0,  32'h0,        32'h456789ab, 1, 32'h0,        2, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b010, 32'd5,  32'h0,        32'h8000f00d, 1, 32'h0,        2, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b001, 32'd3,  32'h12345678, 32'h456789ab, 1, 32'h0,        2, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'd1,  32'h000000aa, 32'h456789ab, 0, 32'h0,        5, 1, 1, 1, 32'h4567aaab));
    vecs.push_back(mk(0, 3'b000, 32'd11, 32'h0,        32'h7f000000, 0, 32'h0000007f, 4, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b000, 32'd10, 32'h0,        32'h00800000, 0, 32'hffffff80, 4, 1, 0, 0, 32'h0));

    #3;
    check_reset_outputs("reset");
    step(); step();
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      submit(vecs[i]);
      expect_done++;
      wait_done();
    end

    // Backpressure: RAM stalls READ for 3 cycles, consumer stalls the response.
    bp = mk(0, 3'b001, 32'd2, 32'h0, 32'h456789ab, 0, 32'h00004567, 0, 1, 0, 0, 32'h0);
    bus.ram_req_ready = 1'b0;
    bus.resp_ready    = 1'b0;
    submit(bp);
    expect_done++;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("stalled ram_req_valid", 32'(bus.ram_req_valid), 32'd1);
      check("stalled req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.ram_req_ready = 1'b1;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      step();
      check("busy req_ready", 32'(bus.req_ready), 32'd0);
      n++;
    end
    check("backpressure resp_valid", 32'(bus.resp_valid), 32'd1);
    step();
    check("held resp_valid", 32'(bus.resp_valid), 32'd1);
    check("held req_ready", 32'(bus.req_ready), 32'd0);
    bus.resp_ready = 1'b1;
    wait_done();

    // Reset while an sh waits for read data; the request must vanish without a write.
    ram_mute = 1'b1;
    submit(mk(1, 3'b001, 32'd0, 32'h1234abcd, 32'h456789ab, 0, 32'h0, 0, 1, 1, 0, 32'h0));
    step(); step(); step();
    check("read_wait ram_req_valid", 32'(bus.ram_req_valid), 32'd0);
    check("read_wait resp_valid", 32'(bus.resp_valid), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async reset");
    wr_base = wr_cnt;
    sb_q.delete();
    ram_mute = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clock);
    stale_req++;
    step(); step(); step();
    check("after stale req_ready", 32'(bus.req_ready), 32'd1);
    check("after stale ram_req_valid", 32'(bus.ram_req_valid), 32'd0);
    check("after stale resp_valid", 32'(bus.resp_valid), 32'd0);
    check("no write after reset", 32'(wr_cnt - wr_base), 32'd0);
    submit(mk(0, 3'b010, 32'd0, 32'h0, 32'h456789ab, 0, 32'h456789ab, 4, 1, 0, 0, 32'h0));
    expect_done++;
    wait_done();

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
Sequences one RISC-V load or store at a time between the execute stage and a 32-bit word-addressed RAM port.
- Instantiates load_store for byte-lane alignment, sign/zero extension, misalignment fault detection and store merge.
- Sub-word stores are performed as read-modify-write.
- Faulting accesses complete without any RAM traffic.

Parameters:
ADDR_WIDTH, 32, width of the byte address; RAM word address is ADDR_WIDTH-2 bits.

Ports:
clock  input  1  sole clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request offered.
req_ready  output  1  sequencer can accept a request.
req_store  input  1  1 = store, 0 = load.
req_funct3  input  3  RISC-V funct3 of the access.
req_address  input  ADDR_WIDTH  byte address.
req_store_value  input  32  rs2 value for stores.
resp_valid  output  1  result available.
resp_ready  input  1  consumer takes result.
resp_efault  output  1  access faulted (misaligned or illegal funct3).
resp_load_value  output  32  extended load result; 0 for stores and faults.
ram_req_valid  output  1  RAM command offered.
ram_req_ready  input  1  RAM accepts command.
ram_req_write  output  1  1 = write, 0 = read.
ram_req_address  output  ADDR_WIDTH-2  word address = address[ADDR_WIDTH-1:2].
ram_req_data  output  32  write data (merged word).
ram_resp_valid  input  1  read data valid; arrives at least 1 cycle after the read command is accepted.
ram_resp_data  input  32  read data.

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is asynchronous and active-high.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_efault 0, resp_load_value 0, ram_req_valid 0, ram_req_write 0, ram_req_address 0, ram_req_data 0.
- Request capture: req_ready = (state == IDLE). On req_valid && req_ready, register store, funct3, address and store_value. Inputs are not sampled again until the next IDLE.
- Fault rules:
  - efault is computed from the registered funct3[1:0] and address[1:0] per load_store.
  - Additionally, a store with funct3[2] = 1 is a fault.
- States:
  - IDLE: on accept, go to DECIDE.
  - DECIDE (1 cycle):
    - fault -> RESP with efault=1;
    - store with funct3 == 010 -> WRITE (full-word store, no read);
    - otherwise -> READ.
  - READ: ram_req_valid=1, write=0, address=word address. On ram_req_ready -> READ_WAIT.
  - READ_WAIT: wait for ram_resp_valid.
    - Capture ram_resp_data as ram_load_value.
    - Load -> RESP with resp_load_value = load_store.load_value.
    - Store -> WRITE with ram_req_data = load_store.ram_store_value.
  - WRITE: ram_req_valid=1, write=1. On ram_req_ready -> RESP, resp_load_value=0.
  - RESP: resp_valid=1. Outputs stay stable until resp_ready. On resp_ready -> IDLE.
- RAM command stability: ram_req_* outputs are held stable while ram_req_valid && !ram_req_ready. ram_req_valid is never withdrawn except by reset.
- ram_resp_valid outside READ_WAIT is ignored, including a stale response after reset.
- Latency (RAM always ready, read data 1 cycle after accept), counted from the accept edge:
  - fault: resp_valid after 2 cycles;
  - sw: after 3 cycles;
  - load: after 4 cycles;
  - sub-word store: after 5 cycles.
- Throughput: one access in flight. req_ready reasserts the cycle after the response handshake (one bubble).
- Undefined load_store outputs (x on fault/unused paths) must never reach ports; ports carry 0 in those cases.
- Reset mid-operation: immediate return to IDLE, ram_req_valid and resp_valid drop asynchronously, the captured request is discarded, and no write is issued.

Test Plan:
- RAM word 0x456789ab at word 0; lb (funct3 000) at address 1 -> one read of word 0, resp_efault 0, resp_load_value 0xffffff89; lbu at 1 -> 0x00000089.
- sb (000) at address 3, store_value 0xffffffff, RAM word 0x456789ab -> read then write with ram_req_data 0xff6789ab; resp_load_value 0.
- lh (001) at address 1, and sw (010) at address 2 -> resp_efault 1 two cycles after accept; zero ram_req_valid cycles.
- sw (010) at address 0, value 0xffffffff -> single write of 0xffffffff to word 0, no read; resp after 3 cycles.
- Backpressure: ram_req_ready low 3 cycles during READ, resp_ready low 2 cycles -> ram_req_* and resp_* held stable; req_ready stays 0 throughout; lh at 2 returns 0x00004567.
- Assert reset while in READ_WAIT of an sh -> outputs return to reset values immediately; a later ram_resp_valid is ignored; no write is issued; the next lw at 0 completes normally with 0x456789ab.
